// File: rtl/feature_frame_loader_if.sv
// Byte-stream handshake bundle between a feature producer and
// feature_frame_loader.
//   in_data   : feature byte (don't-care when in_valid=0)
//   in_valid  : producer presents a byte
//   in_parity : even-parity bit for in_data (checked only with FEATURE_PARITY_EN)
//   in_ready  : loader accepts the byte on this edge
// The master modport is the producer side; the slave modport is the loader side.
interface feature_frame_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_parity;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_parity, input in_ready);
  modport slave  (input in_data, input in_valid, input in_parity, output in_ready);
endinterface

// File: rtl/feature_frame_loader.sv
// feature_frame_loader: upstream stage of the perceptron classifier.
// Collects two bytes from a valid/ready stream (byte0 -> features1,
// byte1 -> features2), commits both buses on one edge, pulses frame_start,
// then holds the frame for HOLD_CYCLES cycles with in_ready low so the
// serial weight-accumulation pass finishes on stable inputs.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : in_data / in_valid / in_parity / in_ready byte stream
//   flush        : aborts a partial frame, or ends a hold early
//   features1/2  : committed byte0 / byte1
//   frame_start  : one-cycle pulse on the cycle a new frame is visible
//   frame_valid  : high while the committed frame is in its hold window
//   frame_count  : committed frames, wraps 255->0
//   err_parity   : sticky parity error
//
// Parameters:
//   HOLD_CYCLES  : cycles in_ready stays low after a commit (>= 1)
//   CNT_W        : hold counter width, 2**CNT_W > HOLD_CYCLES-1
//
// Optional build macro FEATURE_PARITY_EN: when defined, every accepted byte
// must satisfy ^{in_data,in_parity}==0. A failing byte is still handshaken but
// discarded, the partial frame is dropped and err_parity latches high. When
// undefined, in_parity is ignored and err_parity is tied low.
module feature_frame_loader #(
  parameter int HOLD_CYCLES = 96,
  parameter int CNT_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  feature_frame_loader_if.slave bus,
  input  logic                  flush,
  output logic [7:0]            features1,
  output logic [7:0]            features2,
  output logic                  frame_start,
  output logic                  frame_valid,
  output logic [7:0]            frame_count,
  output logic                  err_parity
);

  typedef enum logic [1:0] {IDLE_LO, WAIT_HI, HOLD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       byte0;

  logic accept;     // handshake completes this edge
  logic byte_ok;    // accepted byte passes the parity check (always 1 without it)
  logic stage_en;   // latch byte0
  logic commit;     // publish features1/2
  logic drop;       // discard a staged byte (flush in WAIT_HI or bad byte)
  logic hold_exit;  // last HOLD cycle

`ifdef FEATURE_PARITY_EN
  assign byte_ok = ~^{bus.in_data, bus.in_parity};
`else
  assign byte_ok = 1'b1;
  logic unused_parity;
  assign unused_parity = bus.in_parity;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE_LO;
    else        state <= state_nxt;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_LO: if (accept && byte_ok) state_nxt = WAIT_HI;
      WAIT_HI: begin
        if (flush)                  state_nxt = IDLE_LO;
        else if (accept && byte_ok) state_nxt = HOLD;
        else if (accept)            state_nxt = IDLE_LO;
      end
      HOLD:    if (hold_exit) state_nxt = IDLE_LO;
      default: state_nxt = IDLE_LO;
    endcase
  end

  // ---------------- outputs / strobes ----------------
  // flush masks in_ready, so flush together with in_valid never accepts.
  always_comb begin
    bus.in_ready = ((state == IDLE_LO) || (state == WAIT_HI)) && !flush;
    accept       = bus.in_valid && bus.in_ready;
    stage_en     = (state == IDLE_LO) && accept && byte_ok;
    commit       = (state == WAIT_HI) && accept && byte_ok;
    drop         = ((state == WAIT_HI) && flush) || (accept && !byte_ok);
    hold_exit    = (state == HOLD) && ((hold_cnt == '0) || flush);
  end

  // ---------------- datapath ----------------
  // Counter is loaded with HOLD_CYCLES-1 and HOLD exits on the edge where it
  // reads 0, giving exactly HOLD_CYCLES cycles of in_ready low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte0       <= '0;
      features1   <= '0;
      features2   <= '0;
      frame_start <= 1'b0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      hold_cnt    <= '0;
    end else begin
      frame_start <= commit;
      if (stage_en)  byte0 <= bus.in_data;
      else if (drop) byte0 <= '0;
      if (commit) begin
        features1   <= byte0;
        features2   <= bus.in_data;
        frame_count <= frame_count + 8'd1;
        frame_valid <= 1'b1;
        hold_cnt    <= CNT_W'(HOLD_CYCLES - 1);
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
        if (hold_exit) frame_valid <= 1'b0;
      end
    end
  end

`ifdef FEATURE_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                  err_parity <= 1'b0;
    else if (accept && !byte_ok) err_parity <= 1'b1;
  end
`else
  assign err_parity = 1'b0;
`endif

endmodule
